// File: rtl/fpga_ram_pkg.sv
// Shared types and helpers for the interleaved multi-bank FPGA RAM.
// Contents:
//   lat_e         - read pipeline depth selector (LAT1 / LAT2)
//   init_state_e  - zero-sweep FSM states (INIT / READY)
//   parity_bytes  - per-byte even parity of a word, LSB = byte 0
package fpga_ram_pkg;

  typedef enum logic {LAT1, LAT2} lat_e;

  typedef enum logic {INIT, READY} init_state_e;

  // Upper bound on bytes per word that parity_bytes can handle.
  localparam int unsigned PAR_MAX_BYTES = 128;

  // Callers zero-extend their word into the argument and keep the low BE_WIDTH bits of the
  // result; zero bytes contribute zero parity, so the extension is harmless.
  function automatic logic [PAR_MAX_BYTES-1:0] parity_bytes(
    input logic [8*PAR_MAX_BYTES-1:0] data
  );
    logic [PAR_MAX_BYTES-1:0] par;
    for (int i = 0; i < PAR_MAX_BYTES; i++) begin
      par[i] = ^data[8*i +: 8];
    end
    return par;
  endfunction

endpackage

// File: rtl/fpga_interleaved_ram_multibank_if.sv
// Bank-port bundle between the L2 interconnect (master) and the multi-bank RAM (slave).
// Signals (one lane per bank):
//   csn, wen  - chip select / write enable, both active low (wen=1 means read)
//   be        - byte enables, addr - word address, wdata - write data
//   rdata     - read data (held between reads), rvalid - read-data-valid pulse
//   err       - parity error pulse, aligned with rvalid
interface fpga_interleaved_ram_multibank_if #(
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_BANKS-1:0]                 csn;
  logic [NB_BANKS-1:0]                 wen;
  logic [NB_BANKS-1:0][BE_WIDTH-1:0]   be;
  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] wdata;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] rdata;
  logic [NB_BANKS-1:0]                 rvalid;
  logic [NB_BANKS-1:0]                 err;

  modport master (
    output csn, wen, be, addr, wdata,
    input  rdata, rvalid, err
  );

  modport slave (
    input  csn, wen, be, addr, wdata,
    output rdata, rvalid, err
  );

endinterface

// File: rtl/fpga_ram_bank.sv
// One behavioural byte-enabled single-port RAM bank with read pipeline and hold register.
// Optional build macro: FPGA_RAM_PARITY_EN adds one even-parity bit per byte and a
// per-read parity error pulse; without it o_err is tied low.
// Ports:
//   clk_i, rst_ni   - clock, synchronous active-low reset (clears the read pipeline only)
//   i_req           - RAM enable for this cycle
//   i_we            - 1 = write, 0 = read (only meaningful with i_req)
//   i_be, i_addr, i_wdata - byte enables, word address, write data
//   o_rdata         - read data, holds its value until the next read completes
//   o_rvalid        - one-cycle pulse READ_LATENCY cycles after a read request
//   o_err           - parity mismatch pulse aligned with o_rvalid
module fpga_ram_bank
  import fpga_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_req,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_err
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam lat_e        Lat      = (READ_LATENCY == 2) ? LAT2 : LAT1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  w_err1;

  // Storage array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin : p_mem_wr
    if (i_req && i_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // RAM output register doubles as the hold register: it only loads on a read.
  always_ff @(posedge clk_i) begin : p_mem_rd
    if (!rst_ni) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= i_req && !i_we;
      if (i_req && !i_we) begin
        r_rd_data <= r_mem[i_addr];
      end
    end
  end

`ifdef FPGA_RAM_PARITY_EN
  logic [BE_WIDTH-1:0]        r_par [DEPTH];
  logic [BE_WIDTH-1:0]        r_rd_par;
  logic [8*PAR_MAX_BYTES-1:0] w_wpar_in;
  logic [8*PAR_MAX_BYTES-1:0] w_rpar_in;
  logic [PAR_MAX_BYTES-1:0]   w_wpar_full;
  logic [PAR_MAX_BYTES-1:0]   w_rpar_full;

  always_comb begin
    w_wpar_in                   = '0;
    w_wpar_in[DATA_WIDTH-1:0]   = i_wdata;
    w_rpar_in                   = '0;
    w_rpar_in[DATA_WIDTH-1:0]   = r_rd_data;
    w_wpar_full                 = parity_bytes(w_wpar_in);
    w_rpar_full                 = parity_bytes(w_rpar_in);
  end

  always_ff @(posedge clk_i) begin : p_par_wr
    if (i_req && i_we) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (i_be[i]) begin
          r_par[i_addr][i] <= w_wpar_full[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin : p_par_rd
    if (!rst_ni) begin
      r_rd_par <= '0;
    end else if (i_req && !i_we) begin
      r_rd_par <= r_par[i_addr];
    end
  end

  assign w_err1 = r_rd_valid && (w_rpar_full[BE_WIDTH-1:0] != r_rd_par);
`else
  assign w_err1 = 1'b0;
`endif

  if (Lat == LAT2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_err;

    // r_rd_data already holds between reads, so this stage can load every cycle.
    always_ff @(posedge clk_i) begin : p_out
      if (!rst_ni) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_err   <= 1'b0;
      end else begin
        r_out_data  <= r_rd_data;
        r_out_valid <= r_rd_valid;
        r_out_err   <= w_err1;
      end
    end

    assign o_rdata  = r_out_data;
    assign o_rvalid = r_out_valid;
    assign o_err    = r_out_err;
  end else begin : g_lat1
    assign o_rdata  = r_rd_data;
    assign o_rvalid = r_rd_valid;
    assign o_err    = w_err1;
  end

endmodule

// File: rtl/fpga_interleaved_ram_multibank.sv
// Interleaved L2 region built from NB_BANKS independent behavioural RAM banks.
// After every reset a shared FSM sweeps all addresses of all banks to zero (DEPTH cycles),
// ignoring external requests, then raises init_done_o.
// Optional build macro: FPGA_RAM_PARITY_EN (per-byte parity and err pulses, see fpga_ram_bank).
// Ports:
//   clk_i, rst_ni - clock, synchronous active-low reset
//   ram_bus       - slave side of the per-bank request/response bundle
//   init_done_o   - high once the zero sweep has completed
module fpga_interleaved_ram_multibank
  import fpga_ram_pkg::*;
#(
  parameter int unsigned NB_BANKS     = 4,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  fpga_interleaved_ram_multibank_if.slave       ram_bus,
  output logic                                  init_done_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end

  init_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;
  logic                  w_sweep;
  logic                  w_ready;

  always_ff @(posedge clk_i) begin : p_init_fsm
    if (!rst_ni) begin
      r_state     <= INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else begin
      unique case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state     <= READY;
            r_init_done <= 1'b1;
          end
        end
        READY: ;
        default: r_state <= INIT;
      endcase
    end
  end

  assign init_done_o = r_init_done;

  // Gated with rst_ni so nothing reaches the RAM on a reset edge.
  assign w_sweep = (r_state == INIT) && rst_ni;
  assign w_ready = (r_state == READY) && rst_ni;

  logic [NB_BANKS-1:0]                 w_req;
  logic [NB_BANKS-1:0]                 w_we;
  logic [NB_BANKS-1:0][BE_WIDTH-1:0]   w_be;
  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0] w_addr;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] w_rdata;
  logic [NB_BANKS-1:0]                 w_rvalid;
  logic [NB_BANKS-1:0]                 w_err;

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    assign w_req[b]   = w_sweep | (w_ready & ~ram_bus.csn[b]);
    assign w_we[b]    = w_sweep | ~ram_bus.wen[b];
    assign w_be[b]    = w_sweep ? {BE_WIDTH{1'b1}} : ram_bus.be[b];
    assign w_addr[b]  = w_sweep ? r_cnt : ram_bus.addr[b];
    assign w_wdata[b] = w_sweep ? '0 : ram_bus.wdata[b];

    fpga_ram_bank #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_req    (w_req[b]),
      .i_we     (w_we[b]),
      .i_be     (w_be[b]),
      .i_addr   (w_addr[b]),
      .i_wdata  (w_wdata[b]),
      .o_rdata  (w_rdata[b]),
      .o_rvalid (w_rvalid[b]),
      .o_err    (w_err[b])
    );
  end

  assign ram_bus.rdata  = w_rdata;
  assign ram_bus.rvalid = w_rvalid;
  assign ram_bus.err    = w_err;

endmodule
